// File: rtl/rsp_fifo_drain_pkg.sv
// Shared constants for the response-FIFO drain engine: FSM state encodings,
// the beat width toward the RISC-V core and the default sequence-ID width.
package rsp_fifo_drain_pkg;

  // Default sequence-ID width used when the instantiating level does not override it
  localparam int NOU_SID_WIDTH_DEF = 8;

  // Width of one response beat presented to the core
  localparam int BEAT_W = 32;

  // Drain FSM state encodings (plain constants so legacy tools can consume them)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_SEND_LO = 2'd2;
  localparam logic [1:0] ST_SEND_HI = 2'd3;

  // True in the two states that present a beat to the core
  function automatic logic is_send_state(input logic [1:0] st);
    return (st == ST_SEND_LO) || (st == ST_SEND_HI);
  endfunction

endpackage

// File: rtl/rsp_fifo_drain.sv
// Drains entries from a synchronous-read response FIFO and presents each one
// to the RISC-V core as one (narrow) or two (wide) 32-bit beats with a
// valid/ready handshake. Every entry follows the same path:
// IDLE/last-beat pop -> RD_WAIT capture -> SEND_LO [-> SEND_HI].
module rsp_fifo_drain
  import rsp_fifo_drain_pkg::*;
#(
  parameter int NOU_SID_WIDTH  = NOU_SID_WIDTH_DEF,
  parameter int RSP_DATA_WIDTH = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    rsp_fifo_empty,
  output logic                                    rsp_fifo_rd_en,
  input  logic [NOU_SID_WIDTH+RSP_DATA_WIDTH:0]   rsp_fifo_rd_data,
  output logic                                    rv_rsp_vld,
  input  logic                                    rv_rsp_rdy,
  output logic [BEAT_W-1:0]                       rv_rsp_data,
  output logic [NOU_SID_WIDTH-1:0]                rv_rsp_sid,
  output logic                                    rv_rsp_last,
  output logic                                    drain_busy,
  output logic [15:0]                             rsp_cnt
);

  localparam int ENTRY_W = 1 + NOU_SID_WIDTH + RSP_DATA_WIDTH;

  logic [1:0]         state_q, state_d;
  logic [ENTRY_W-1:0] hold_q, hold_d;
  logic [15:0]        cnt_q, cnt_d;

  logic wide;
  logic last_hs;

  assign wide = hold_q[ENTRY_W-1];

  // Beat presentation: outputs are zero whenever no beat is valid, and are
  // taken purely from the holding register so they stay stable until accepted
  always_comb begin
    rv_rsp_vld  = 1'b0;
    rv_rsp_data = '0;
    rv_rsp_sid  = '0;
    rv_rsp_last = 1'b0;
    if (is_send_state(state_q)) begin
      rv_rsp_vld = 1'b1;
      rv_rsp_sid = hold_q[RSP_DATA_WIDTH +: NOU_SID_WIDTH];
      if (state_q == ST_SEND_LO) begin
        rv_rsp_data = hold_q[BEAT_W-1:0];
        rv_rsp_last = ~wide;
      end else begin
        rv_rsp_data = hold_q[2*BEAT_W-1:BEAT_W];
        rv_rsp_last = 1'b1;
      end
    end
  end

  assign last_hs = rv_rsp_vld & rv_rsp_rdy & rv_rsp_last;

  // Pop when idle or when the final beat of an entry is accepted, so a queued
  // entry follows with a single bubble; reset holds the pop off immediately
  assign rsp_fifo_rd_en = ~rst & ~rsp_fifo_empty & ((state_q == ST_IDLE) | last_hs);

  assign drain_busy = (state_q != ST_IDLE);
  assign rsp_cnt    = cnt_q;

  // Next-state, capture and completion-count logic
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q + {15'd0, last_hs};
    case (state_q)
      ST_IDLE: begin
        if (!rsp_fifo_empty) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        hold_d  = rsp_fifo_rd_data;
        state_d = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (rv_rsp_rdy) begin
          if (wide)                state_d = ST_SEND_HI;
          else if (rsp_fifo_empty) state_d = ST_IDLE;
          else                     state_d = ST_RD_WAIT;
        end
      end
      ST_SEND_HI: begin
        if (rv_rsp_rdy) state_d = rsp_fifo_empty ? ST_IDLE : ST_RD_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any entry in flight and clears the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
